// File: rtl/coproc_host_link_if.sv
// coproc_host_link_if
//   Bundles the request/response handshake and the UART link pins of the
//   coprocessor host link.
//   slave  : view used by coproc_host_link (drives tx, valid_out, responses)
//   master : view used by the local logic / link model (drives requests, rx)
// Signals:
//   req_valid/req_ready/req_frame      request frame handshake
//   rsp_valid/rsp_frame                received response frame + strobe
//   rsp_timeout, rx_err                one-cycle status pulses
//   tx, rx, valid_out                  link pins to the coprocessor
//   busy                               inverse of req_ready
interface coproc_host_link_if #(
  parameter int DBITS       = 8,
  parameter int FRAME_BYTES = 18
);
  logic                           req_valid;
  logic                           req_ready;
  logic [FRAME_BYTES*DBITS-1:0]   req_frame;
  logic                           rsp_valid;
  logic [FRAME_BYTES*DBITS-1:0]   rsp_frame;
  logic                           rsp_timeout;
  logic                           rx_err;
  logic                           tx;
  logic                           rx;
  logic                           valid_out;
  logic                           busy;

  modport master (
    output req_valid, req_frame, rx,
    input  req_ready, rsp_valid, rsp_frame, rsp_timeout, rx_err, tx, valid_out, busy
  );

  modport slave (
    input  req_valid, req_frame, rx,
    output req_ready, rsp_valid, rsp_frame, rsp_timeout, rx_err, tx, valid_out, busy
  );
endinterface

// File: rtl/coproc_host_link.sv
// coproc_host_link
//   Host-side initiator for the UART coprocessor link. Serialises a request
//   frame 8N1 on tx, pulses valid_out, then collects the response frame from
//   rx (only while waiting for it) or reports a timeout.
// Ports:
//   clk_100MHz  sole clock
//   reset       synchronous, active-high
//   bus         coproc_host_link_if.slave: request/response handshake,
//               tx/rx/valid_out link pins, busy status
//
// state    | meaning
// ---------+----------------------------------------------------------
// S_IDLE   | ready for a request frame, tx idle high
// S_TX     | shifting the frame out, start/data/stop per byte
// S_STROBE | valid_out high for STROBE_CYCLES clocks
// S_WAIT   | receiving the response frame, timeout counter running
module coproc_host_link #(
  parameter int DBITS          = 8,
  parameter int FRAME_BYTES    = 18,
  parameter int CLKS_PER_BIT   = 897,
  parameter int STROBE_CYCLES  = 64,
  parameter int TIMEOUT_CYCLES = 2_000_000
) (
  input  logic                 clk_100MHz,
  input  logic                 reset,
  coproc_host_link_if.slave    bus
);

  localparam int FW     = FRAME_BYTES * DBITS;
  localparam int BAUD_W = $clog2(CLKS_PER_BIT + 1);
  localparam int BIT_W  = $clog2(DBITS + 3);
  localparam int BYTE_W = $clog2(FRAME_BYTES + 1);
  localparam int STB_W  = $clog2(STROBE_CYCLES + 1);
  localparam int TO_W   = $clog2(TIMEOUT_CYCLES + 1);

  localparam logic [1:0] S_IDLE   = 2'd0;
  localparam logic [1:0] S_TX     = 2'd1;
  localparam logic [1:0] S_STROBE = 2'd2;
  localparam logic [1:0] S_WAIT   = 2'd3;

  localparam logic [BAUD_W-1:0] BAUD_RELOAD = BAUD_W'(CLKS_PER_BIT - 1);
  localparam logic [BAUD_W-1:0] BAUD_HALF   = BAUD_W'(CLKS_PER_BIT / 2 - 1);
  localparam logic [BIT_W-1:0]  BIT_STOP    = BIT_W'(DBITS + 1);
  localparam logic [BIT_W-1:0]  BIT_DATA    = BIT_W'(DBITS);

  logic [1:0]        r_state;
  logic [FW-1:0]     r_tx_shift;
  logic [BAUD_W-1:0] r_tx_baud;
  logic [BIT_W-1:0]  r_tx_bit;
  logic [BYTE_W-1:0] r_tx_byte;
  logic              r_tx;
  logic              r_valid_out;
  logic [STB_W-1:0]  r_stb_cnt;
  logic [TO_W-1:0]   r_to_cnt;
  logic              r_req_ready;
  logic              r_busy;

  logic              r_rx_s1;
  logic              r_rx_s2;
  logic              r_rx_s3;
  logic              r_rx_active;
  logic [BAUD_W-1:0] r_rx_baud;
  logic [BIT_W-1:0]  r_rx_bit;
  logic [DBITS-1:0]  r_rx_shift;
  logic [BYTE_W-1:0] r_rx_count;
  logic [FW-1:0]     r_rx_buf;
  logic [FW-1:0]     r_rsp_frame;
  logic              r_rsp_valid;
  logic              r_rsp_timeout;
  logic              r_rx_err;

  logic              w_rx_fall;
  logic              w_stop_ok;
  logic              w_frame_done;
  logic [FW-1:0]     w_buf_upd;

  // Bytes shift in from the top, so after FRAME_BYTES accepted characters
  // byte 0 sits in the low bits regardless of any earlier partial frame.
  always_comb begin
    w_rx_fall    = r_rx_s3 & ~r_rx_s2;
    w_stop_ok    = r_rx_active && (r_rx_baud == '0) && (r_rx_bit == BIT_STOP) && r_rx_s2;
    w_frame_done = w_stop_ok && (r_rx_count == BYTE_W'(FRAME_BYTES - 1));
    w_buf_upd    = {r_rx_shift, r_rx_buf[FW-1:DBITS]};
  end

  always_ff @(posedge clk_100MHz) begin
    if (reset) begin
      r_rx_s1 <= 1'b1;
      r_rx_s2 <= 1'b1;
      r_rx_s3 <= 1'b1;
    end else begin
      r_rx_s1 <= bus.rx;
      r_rx_s2 <= r_rx_s1;
      r_rx_s3 <= r_rx_s2;
    end
  end

  always_ff @(posedge clk_100MHz) begin
    if (reset) begin
      r_state       <= S_IDLE;
      r_tx_shift    <= '0;
      r_tx_baud     <= '0;
      r_tx_bit      <= '0;
      r_tx_byte     <= '0;
      r_tx          <= 1'b1;
      r_valid_out   <= 1'b0;
      r_stb_cnt     <= '0;
      r_to_cnt      <= '0;
      r_req_ready   <= 1'b1;
      r_busy        <= 1'b0;
      r_rx_active   <= 1'b0;
      r_rx_baud     <= '0;
      r_rx_bit      <= '0;
      r_rx_shift    <= '0;
      r_rx_count    <= '0;
      r_rx_buf      <= '0;
      r_rsp_frame   <= '0;
      r_rsp_valid   <= 1'b0;
      r_rsp_timeout <= 1'b0;
      r_rx_err      <= 1'b0;
    end else begin
      r_rsp_valid   <= 1'b0;
      r_rsp_timeout <= 1'b0;
      r_rx_err      <= 1'b0;

      case (r_state)
        S_IDLE: begin
          if (bus.req_valid) begin
            r_state     <= S_TX;
            r_tx_shift  <= bus.req_frame;
            r_tx_byte   <= '0;
            r_tx_bit    <= '0;
            r_tx_baud   <= BAUD_RELOAD;
            r_tx        <= 1'b0;
            r_req_ready <= 1'b0;
            r_busy      <= 1'b1;
          end
        end

        S_TX: begin
          if (r_tx_baud != '0) begin
            r_tx_baud <= r_tx_baud - 1'b1;
          end else begin
            r_tx_baud <= BAUD_RELOAD;
            if (r_tx_bit == BIT_STOP) begin
              if (r_tx_byte == BYTE_W'(FRAME_BYTES - 1)) begin
                r_state     <= S_STROBE;
                r_valid_out <= 1'b1;
                r_stb_cnt   <= STB_W'(STROBE_CYCLES - 1);
              end else begin
                r_tx_byte <= r_tx_byte + 1'b1;
                r_tx_bit  <= '0;
                r_tx      <= 1'b0;
              end
            end else begin
              r_tx_bit <= r_tx_bit + 1'b1;
              // The whole frame shifts right one bit per data bit, so the
              // next bit to send is always at position 0.
              if (r_tx_bit < BIT_DATA) begin
                r_tx       <= r_tx_shift[0];
                r_tx_shift <= r_tx_shift >> 1;
              end else begin
                r_tx <= 1'b1;
              end
            end
          end
        end

        S_STROBE: begin
          if (r_stb_cnt == '0) begin
            r_valid_out <= 1'b0;
            r_state     <= S_WAIT;
            r_to_cnt    <= TO_W'(TIMEOUT_CYCLES - 1);
            r_rx_count  <= '0;
            r_rx_active <= 1'b0;
          end else begin
            r_stb_cnt <= r_stb_cnt - 1'b1;
          end
        end

        default: begin
          // A frame completing on the timeout cycle takes precedence.
          if (w_frame_done) begin
            r_rsp_frame <= w_buf_upd;
            r_rsp_valid <= 1'b1;
            r_state     <= S_IDLE;
            r_req_ready <= 1'b1;
            r_busy      <= 1'b0;
            r_rx_active <= 1'b0;
          end else if (r_to_cnt == '0) begin
            r_rsp_timeout <= 1'b1;
            r_state       <= S_IDLE;
            r_req_ready   <= 1'b1;
            r_busy        <= 1'b0;
            r_rx_active   <= 1'b0;
          end else begin
            r_to_cnt <= r_to_cnt - 1'b1;
            if (!r_rx_active) begin
              if (w_rx_fall) begin
                r_rx_active <= 1'b1;
                r_rx_baud   <= BAUD_HALF;
                r_rx_bit    <= '0;
              end
            end else if (r_rx_baud != '0) begin
              r_rx_baud <= r_rx_baud - 1'b1;
            end else begin
              r_rx_baud <= BAUD_RELOAD;
              if (r_rx_bit == '0) begin
                // Start bit high at mid-bit: a glitch, go back to hunting.
                if (r_rx_s2) r_rx_active <= 1'b0;
                else         r_rx_bit    <= 1'b1;
              end else if (r_rx_bit <= BIT_DATA) begin
                r_rx_shift <= {r_rx_s2, r_rx_shift[DBITS-1:1]};
                r_rx_bit   <= r_rx_bit + 1'b1;
              end else begin
                r_rx_active <= 1'b0;
                if (r_rx_s2) begin
                  r_rx_buf   <= w_buf_upd;
                  r_rx_count <= r_rx_count + 1'b1;
                end else begin
                  r_rx_err <= 1'b1;
                end
              end
            end
          end
        end
      endcase
    end
  end

  assign bus.req_ready   = r_req_ready;
  assign bus.busy        = r_busy;
  assign bus.tx          = r_tx;
  assign bus.valid_out   = r_valid_out;
  assign bus.rsp_valid   = r_rsp_valid;
  assign bus.rsp_frame   = r_rsp_frame;
  assign bus.rsp_timeout = r_rsp_timeout;
  assign bus.rx_err      = r_rx_err;

endmodule

// File: tb/tb_coproc_host_link.sv
// tb_coproc_host_link
//   Directed bench for coproc_host_link with a behavioural link model:
//   the expected tx waveform, strobe window, timeout cycle and handshake
//   levels are derived from the accept cycle and the frame contents.
module tb_coproc_host_link;
  localparam int DBITS = 8;
  localparam int FB    = 2;
  localparam int CPB   = 4;
  localparam int SC    = 3;
  localparam int TO    = 200;
  localparam int FW    = FB * DBITS;
  localparam int TXLEN = FB * (DBITS + 2) * CPB;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  coproc_host_link_if #(.DBITS(DBITS), .FRAME_BYTES(FB)) bus ();

  coproc_host_link #(
    .DBITS(DBITS), .FRAME_BYTES(FB), .CLKS_PER_BIT(CPB),
    .STROBE_CYCLES(SC), .TIMEOUT_CYCLES(TO)
  ) dut (
    .clk_100MHz(clk),
    .reset(reset),
    .bus(bus)
  );

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int n_checks = 0;
  int n_fail   = 0;

  // model state
  int          acc = -1;
  logic [FW-1:0] req_m = '0;
  bit          txn_open = 0;
  bit          to_mode = 0;
  bit          rsp_expected = 0;
  logic [FW-1:0] exp_rsp = '0;
  logic [FW-1:0] hold = '0;
  int          t_last_stop = -100;
  int          n_rsp = 0, n_to = 0, n_err = 0, t_to = -1;
  bit          chk_en = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s at cycle %0d: got %0h, expected %0h", name, cyc, act, exp);
    end
  endtask

  function automatic logic m_tx(input int c);
    int k, idx, b, byt;
    if (acc < 0 || c <= acc) return 1'b1;
    k   = c - acc - 1;
    idx = k / CPB;
    if (idx >= FB * (DBITS + 2)) return 1'b1;
    byt = idx / (DBITS + 2);
    b   = idx % (DBITS + 2);
    if (b == 0) return 1'b0;
    if (b == DBITS + 1) return 1'b1;
    return req_m[byt * DBITS + b - 1];
  endfunction

  function automatic logic m_vo(input int c);
    int s;
    s = acc + 1 + TXLEN;
    return (acc >= 0) && (c >= s) && (c < s + SC);
  endfunction

  always @(negedge clk) begin : cmp
    int   c;
    int   w;
    logic er;
    if (chk_en) begin
      c = cyc;
      w = acc + 1 + TXLEN + SC;
      check("tx", bus.tx, m_tx(c));
      check("valid_out", bus.valid_out, m_vo(c));
      if (txn_open && to_mode && acc >= 0 && c == w + TO) txn_open = 0;
      check("rsp_timeout", bus.rsp_timeout, to_mode && acc >= 0 && c == w + TO);
      if (bus.rsp_timeout) begin
        n_to++;
        t_to = c;
      end
      if (bus.rsp_valid) begin
        n_rsp++;
        check("rsp_valid_expected", rsp_expected, 1'b1);
        check("rsp_valid_window", (c > t_last_stop) && (c <= t_last_stop + CPB + 3), 1'b1);
        check("rsp_frame_on_valid", bus.rsp_frame, exp_rsp);
        hold = exp_rsp;
        txn_open = 0;
        rsp_expected = 0;
      end else begin
        check("rsp_frame_hold", bus.rsp_frame, hold);
      end
      er = !(txn_open && acc >= 0 && c > acc);
      check("req_ready", bus.req_ready, er);
      check("busy", bus.busy, !er);
      if (bus.rx_err) n_err++;
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_until(input int t);
    while (cyc < t) tick();
  endtask

  task automatic request(input logic [FW-1:0] f, input bit keep);
    bus.req_valid = 1'b1;
    bus.req_frame = f;
    acc      = cyc;
    req_m    = f;
    txn_open = 1;
    tick();
    if (!keep) bus.req_valid = 1'b0;
  endtask

  task automatic send_byte(input logic [7:0] b, input bit stop);
    for (int i = 0; i < DBITS + 2; i++) begin
      if (i == 0)              bus.rx = 1'b0;
      else if (i == DBITS + 1) begin
        bus.rx = stop;
        if (stop) t_last_stop = cyc;
      end else                 bus.rx = b[i-1];
      repeat (CPB) tick();
    end
  endtask

  task automatic gap(input int bits);
    bus.rx = 1'b1;
    repeat (bits * CPB) tick();
  endtask

  task automatic clear_counts();
    n_rsp = 0; n_to = 0; n_err = 0; t_to = -1;
  endtask

  bit lit_tx [20] = '{0,1,0,1,0,0,1,0,1,1, 0,0,1,0,1,1,0,1,0,1};

  initial begin
    reset         = 1'b1;
    bus.req_valid = 1'b0;
    bus.req_frame = '0;
    bus.rx        = 1'b1;
    repeat (3) tick();

    check("reset_tx", bus.tx, 1'b1);
    check("reset_valid_out", bus.valid_out, 1'b0);
    check("reset_req_ready", bus.req_ready, 1'b1);
    check("reset_busy", bus.busy, 1'b0);
    check("reset_rsp_valid", bus.rsp_valid, 1'b0);
    check("reset_rsp_timeout", bus.rsp_timeout, 1'b0);
    check("reset_rx_err", bus.rx_err, 1'b0);
    check("reset_rsp_frame", bus.rsp_frame, 16'h0000);

    reset  = 1'b0;
    tick();
    chk_en = 1;
    repeat (2) tick();

    // request serialisation + response capture
    clear_counts();
    request(16'h5AA5, 0);
    check("accept_req_ready_low", bus.req_ready, 1'b0);
    for (int i = 0; i < 20; i++) begin
      wait_until(acc + 1 + CPB * i + 2);
      check("tx_literal_bit", bus.tx, lit_tx[i]);
    end
    wait_until(acc + 80); check("vo_c80", bus.valid_out, 1'b0);
    wait_until(acc + 81); check("vo_c81", bus.valid_out, 1'b1);
    wait_until(acc + 83); check("vo_c83", bus.valid_out, 1'b1);
    wait_until(acc + 84); check("vo_c84", bus.valid_out, 1'b0);
    exp_rsp      = 16'hC33C;
    rsp_expected = 1;
    gap(1);
    send_byte(8'h3C, 1);
    send_byte(8'hC3, 1);
    repeat (10) tick();
    check("resp_count", n_rsp, 1);
    check("resp_frame_literal", bus.rsp_frame, 16'hC33C);
    check("resp_no_err", n_err, 0);

    // timeout
    clear_counts();
    to_mode = 1;
    request(16'h1234, 0);
    wait_until(acc + 1 + TXLEN + SC + TO + 5);
    check("timeout_count", n_to, 1);
    check("timeout_cycle", t_to - acc, 284);
    check("timeout_frame_kept", bus.rsp_frame, 16'hC33C);
    check("timeout_idle", bus.req_ready, 1'b1);
    to_mode = 0;
    repeat (3) tick();

    // framing error then a good frame
    clear_counts();
    request(16'h0F0F, 0);
    wait_until(acc + 1 + TXLEN + SC);
    gap(1);
    send_byte(8'hAB, 0);
    gap(3);
    exp_rsp      = 16'h2211;
    rsp_expected = 1;
    send_byte(8'h11, 1);
    gap(1);
    send_byte(8'h22, 1);
    repeat (10) tick();
    check("ferr_rx_err_count", n_err, 1);
    check("ferr_rsp_count", n_rsp, 1);
    check("ferr_frame_literal", bus.rsp_frame, 16'h2211);

    // traffic on rx outside WAIT_RSP, req_valid held while busy
    clear_counts();
    send_byte(8'h77, 1);
    gap(2);
    request(16'hBEEF, 1);
    wait_until(acc + 10);
    send_byte(8'h99, 1);
    wait_until(acc + 80);
    bus.rx = 1'b0;
    repeat (2) tick();
    bus.rx = 1'b1;
    wait_until(acc + 1 + TXLEN + SC);
    bus.req_valid = 1'b0;
    exp_rsp      = 16'h0201;
    rsp_expected = 1;
    gap(1);
    send_byte(8'h01, 1);
    send_byte(8'h02, 1);
    repeat (10) tick();
    check("ign_rsp_count", n_rsp, 1);
    check("ign_frame_literal", bus.rsp_frame, 16'h0201);
    check("ign_no_err", n_err, 0);

    // reset in the middle of a TX byte
    clear_counts();
    request(16'hA5A5, 0);
    wait_until(acc + 30);
    reset = 1'b1;
    tick();
    reset        = 1'b0;
    acc          = -1;
    txn_open     = 0;
    hold         = '0;
    rsp_expected = 0;
    check("mrst_tx", bus.tx, 1'b1);
    check("mrst_req_ready", bus.req_ready, 1'b1);
    check("mrst_frame", bus.rsp_frame, 16'h0000);
    repeat (300) tick();
    check("mrst_no_rsp", n_rsp, 0);
    check("mrst_no_timeout", n_to, 0);
    check("mrst_no_err", n_err, 0);

    chk_en = 0;
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
